// File: rtl/fa16_rev.sv
// ---------------------------------------------------------------------------
// fa16_rev_seq
//
// Sequencer for an external 16-bit reversible adder (fa16_rev). Each operand
// set is driven forward through the adder, the forward result is captured and
// driven backward, and the recovered inputs are compared with the originals.
// The sum/carry is then presented on a valid/ready result port together with
// a per-result uncompute-error flag and a saturating error counter.
//
// Parameters
//   SETTLE    cycles each adder direction is held before sampling (1..15)
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           operand handshake (in_a, in_b, in_c0)
//   out_valid/out_ready         result handshake (out_s, out_cout, out_err)
//   err_count                   saturating count of uncompute mismatches
//   busy, dir                   not-IDLE flag, adder direction (1 = backward)
//   f_a, f_b, f_c0_f, f_z       forward drive to the adder
//   f_s, f_a_b, f_c0_b, f_c15   forward result from the adder
//   r_s, r_a_b, r_c0_b, r_c15   backward drive to the adder
//   r_a, r_b, r_c0_f, r_z       recovered inputs from the adder
// ---------------------------------------------------------------------------
module fa16_rev_seq #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_c0,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_s,
  output logic        out_cout,
  output logic        out_err,
  output logic [7:0]  err_count,
  output logic        busy,
  output logic        dir,
  output logic [15:0] f_a,
  output logic [15:0] f_b,
  output logic        f_c0_f,
  output logic        f_z,
  input  logic [15:0] f_s,
  input  logic [15:0] f_a_b,
  input  logic        f_c0_b,
  input  logic        f_c15,
  output logic [15:0] r_s,
  output logic [15:0] r_a_b,
  output logic        r_c0_b,
  output logic        r_c15,
  input  logic [15:0] r_a,
  input  logic [15:0] r_b,
  input  logic        r_c0_f,
  input  logic        r_z
);

  typedef enum logic [1:0] {IDLE, FWD, BWD, OUT} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic        op_c0_q, op_c0_d;
  logic [15:0] res_s_q, res_s_d, res_ab_q, res_ab_d;
  logic        res_c0b_q, res_c0b_d, res_c15_q, res_c15_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        out_err_q, out_err_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        busy_q, busy_d;
  logic        dir_q, dir_d;
  logic        mismatch;

  // Mismatch defaults to 1 and is cleared only on a definite match, so an
  // unknown value on any recovered input falls through as a mismatch.
  always_comb begin
    mismatch = 1'b1;
    if ((r_a == op_a_q) && (r_b == op_b_q) && (r_c0_f == op_c0_q) && (r_z == 1'b0))
      mismatch = 1'b0;
  end

  // Next-state and next-output logic; every output is taken from a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_c0_d     = op_c0_q;
    res_s_d     = res_s_q;
    res_ab_d    = res_ab_q;
    res_c0b_d   = res_c0b_q;
    res_c15_d   = res_c15_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    err_count_d = err_count_q;
    busy_d      = busy_q;
    dir_d       = dir_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_a_d     = in_a;
          op_b_d     = in_b;
          op_c0_d    = in_c0;
          cnt_d      = RELOAD;
          state_d    = FWD;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          dir_d      = 1'b0;
        end
      end
      FWD: begin
        if (cnt_q == 4'd0) begin
          res_s_d   = f_s;
          res_ab_d  = f_a_b;
          res_c0b_d = f_c0_b;
          res_c15_d = f_c15;
          cnt_d     = RELOAD;
          state_d   = BWD;
          dir_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      BWD: begin
        if (cnt_q == 4'd0) begin
          out_err_d   = mismatch;
          if (mismatch && (err_count_q != 8'hFF))
            err_count_d = err_count_q + 8'd1;
          state_d     = OUT;
          out_valid_d = 1'b1;
          dir_d       = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      OUT: begin
        // Ready is raised only after the handshake edge, so a new operand
        // can never be taken on the same edge a result leaves.
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      op_a_q      <= 16'd0;
      op_b_q      <= 16'd0;
      op_c0_q     <= 1'b0;
      res_s_q     <= 16'd0;
      res_ab_q    <= 16'd0;
      res_c0b_q   <= 1'b0;
      res_c15_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      err_count_q <= 8'd0;
      busy_q      <= 1'b0;
      dir_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_c0_q     <= op_c0_d;
      res_s_q     <= res_s_d;
      res_ab_q    <= res_ab_d;
      res_c0b_q   <= res_c0b_d;
      res_c15_q   <= res_c15_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
      busy_q      <= busy_d;
      dir_q       <= dir_d;
    end
  end

  // Adder drives hold the last operand/result so the adder never sees glitches.
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_s     = res_s_q;
  assign out_cout  = res_c15_q;
  assign out_err   = out_err_q;
  assign err_count = err_count_q;
  assign busy      = busy_q;
  assign dir       = dir_q;
  assign f_a       = op_a_q;
  assign f_b       = op_b_q;
  assign f_c0_f    = op_c0_q;
  assign f_z       = 1'b0;
  assign r_s       = res_s_q;
  assign r_a_b     = res_ab_q;
  assign r_c0_b    = res_c0b_q;
  assign r_c15     = res_c15_q;

endmodule

// File: doc/fa16_rev_seq.md
FA16_REV_SEQ -- requirements
Module: fa16_rev_seq

Interface
REQ-001 Parameter SETTLE, default 2, meaning cycles each direction is held before sampling; legal values 1..15.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 in_valid / in_ready  in / out  1  operand handshake.
REQ-005 in_a, in_b  in  16  addends.
REQ-006 in_c0  in  1  carry-in.
REQ-007 out_valid / out_ready  out / in  1  result handshake.
REQ-008 out_s  out  16  sum.
REQ-009 out_cout  out  1  carry-out.
REQ-010 out_err  out  1  uncompute check failed for this result.
REQ-011 err_count  out  8  saturating mismatch count.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 dir  out  1  adder direction; 0 = forward, 1 = backward.
REQ-014 f_a, f_b / f_c0_f, f_z  out  16 / 1  forward drive to fa16_rev.
REQ-015 f_s, f_a_b / f_c0_b, f_c15  in  16 / 1  forward result from fa16_rev.
REQ-016 r_s, r_a_b / r_c0_b, r_c15  out  16 / 1  backward drive to fa16_rev.
REQ-017 r_a, r_b / r_c0_f, r_z  in  16 / 1  recovered inputs from fa16_rev.

Function
REQ-018 FSM states: IDLE, FWD, BWD, OUT; one-hot or binary at implementer's choice.
REQ-019 in_ready = 1 only in IDLE; acceptance = in_valid & in_ready at an edge; in_a/in_b/in_c0 latched there (op_a, op_b, op_c0).
REQ-020 Accept at edge k -> FWD; settle counter loaded to SETTLE-1 and decremented each cycle.
REQ-021 In FWD: dir=0, f_a=op_a, f_b=op_b, f_c0_f=op_c0, f_z=0.
REQ-022 At edge k+SETTLE (counter 0 in FWD): capture f_s, f_a_b, f_c0_b, f_c15 into res_s, res_ab, res_c0b, res_c15; -> BWD; counter reloaded.
REQ-023 In BWD: dir=1, r_s=res_s, r_a_b=res_ab, r_c0_b=res_c0b, r_c15=res_c15.
REQ-024 At edge k+2*SETTLE (counter 0 in BWD): mismatch = (r_a!=op_a)|(r_b!=op_b)|(r_c0_f!=op_c0)|(r_z!=0), with X/Z on any r_* input counted as mismatch; out_err<=mismatch; -> OUT.
REQ-025 On that same edge, when mismatch=1, err_count increments, saturating at 8'hFF (no wrap).
REQ-026 In OUT: out_valid=1, out_s=res_s, out_cout=res_c15; dir=0; all payloads stable until out_valid & out_ready.
REQ-027 out_valid & out_ready at an edge -> IDLE; the next operand is accepted no earlier than the following edge (no same-edge overlap).
REQ-028 Result latency: out_valid rises at edge k+2*SETTLE; throughput one op per 2*SETTLE+2 cycles minimum.
REQ-029 In IDLE and OUT: dir=0, f_* hold last op values, r_* hold last res values; all outputs are register-driven, with no combinational path from in_* to outputs.
REQ-030 dir changes only at FSM transition edges; never toggles within FWD or BWD.
REQ-031 in_valid during a busy state is ignored (not queued); the upstream holds it.

Reset
REQ-032 rst_n low: immediately state=IDLE, dir=0, in_ready=1 after release, out_valid=0, out_err=0, err_count=0, busy=0, op_*/res_* and f_*/r_* = 0.
REQ-033 Reset mid-FWD/BWD/OUT aborts the operation; no result is emitted and err_count is cleared.

Verification
REQ-034 SETTLE=2, a=16'h1234, b=16'h0001, c0=0, ideal adder model -> out_valid at edge k+4, out_s=16'h1235, out_cout=0, out_err=0.
REQ-035 a=16'hFFFF, b=16'h0001, c0=1 -> out_s=16'h0001, out_cout=1; dir=0 for cycles k+1..k+2, dir=1 for k+3..k+4.
REQ-036 out_ready held low 5 cycles in OUT -> out_valid, out_s, out_cout, out_err stable; in_ready=0; busy=1 throughout.
REQ-037 Bench flips r_a[0] during BWD -> out_err=1, err_count 0->1; repeat 300 faulty ops -> err_count stops at 8'hFF.
REQ-038 rst_n pulsed low mid-BWD -> dir=0 and out_valid=0 asynchronously; after release in_ready=1, then the next op completes normally.
REQ-039 Back-to-back in_valid held high, out_ready=1, SETTLE=1 -> one accept every 4 cycles, results in order, no dropped or duplicated op.
